shot_clock_timer: RTL
=====================

Name: shot_clock_timer

Overview:
Parametrised shot-clock countdown for the basketball scoreboard, successor to the fixed 24-second regressive counter. It contains an internal prescaler, so the system clock drives it directly with no external 1 Hz clock. It supports two reload values: full (24) and short (14, offensive-rebound rule). It produces a timed buzzer pulse and a one-cycle expiry strobe. The count output feeds the existing BCD/7-segment display path; the buzzer output drives the horn.

Parameters:
COUNT_W, 5, width of the count output; must satisfy 2^COUNT_W > FULL_LOAD
FULL_LOAD, 24, value loaded by reset and by reload_full
SHORT_LOAD, 14, value loaded by reload_short when the current count is below it; must be less than or equal to FULL_LOAD
TICK_DIV, 50000000, clock_in cycles per one-second decrement; must be at least 2
BUZZ_CYCLES, 50000000, number of cycles the buzzer stays high after expiry; must be at least 1

Ports:
clock_in  input  1  system clock; all logic on its rising edge
reset  input  1  synchronous, active-high reset
run  input  1  level; 1 = count down, 0 = hold (pause)
reload_full  input  1  single-cycle strobe; load FULL_LOAD
reload_short  input  1  single-cycle strobe; load SHORT_LOAD if count < SHORT_LOAD
count  output  COUNT_W  current seconds remaining
expired  output  1  level; high while count == 0 and no reload has occurred
expire_pulse  output  1  one-cycle strobe on the 1->0 count transition
buzzer  output  1  horn drive

Behaviour:
- Single clock domain; all outputs are registered.
- Reset values: count = FULL_LOAD, prescaler = 0, state = HOLD, expired = 0, expire_pulse = 0, buzzer = 0, buzzer timer = 0.
- States:
  - HOLD: count frozen.
  - RUN: prescaler advancing.
  - EXPIRED: count == 0.
- Transitions:
  - HOLD to RUN when run = 1 and count != 0.
  - RUN to HOLD when run = 0.
  - RUN to EXPIRED on the tick that takes count from 1 to 0.
  - EXPIRED to HOLD or RUN on any effective reload. The next state follows run: RUN if run = 1, HOLD if run = 0.
- Prescaler:
  - Counts 0 to TICK_DIV-1 only in RUN.
  - A tick occurs on the cycle the prescaler equals TICK_DIV-1. The prescaler wraps to 0 and count decrements by 1 on the same edge.
  - While in HOLD, the prescaler holds its value, so pause and resume does not lose a partial second.
  - An effective reload clears the prescaler to 0.
- First decrement latency: TICK_DIV cycles after run rises, measured from a cleared prescaler.
- Expiry:
  - On the 1->0 tick, count becomes 0 on that edge.
  - On the following edge, expire_pulse = 1 for exactly one cycle, expired = 1, buzzer = 1, and the buzzer timer is loaded.
  - buzzer stays high for exactly BUZZ_CYCLES cycles, then drops.
  - expired stays high until an effective reload, independent of buzzer.
  - In EXPIRED, run and ticks are ignored. Count never wraps below 0.
- Reload priority: reset > reload_full > reload_short > tick. A reload in the same cycle as a tick wins; no decrement occurs in that cycle.
- reload_full:
  - Always effective, even if count already equals FULL_LOAD.
  - Sets count = FULL_LOAD, clears the prescaler, drops buzzer and expired immediately on the next edge, and clears the buzzer timer.
- reload_short:
  - Effective only if count < SHORT_LOAD, including count == 0. In that case it behaves like reload_full but loads SHORT_LOAD.
  - If count >= SHORT_LOAD it is ignored: count, prescaler and state are unchanged.
- Simultaneous reload_full and reload_short: reload_full wins.
- A reload while the buzzer is active truncates the buzzer on the next edge.
- A reset mid-count or mid-buzz returns all registers to their reset values on the next edge.
- Inputs run, reload_full and reload_short are synchronous to clock_in. Synchronising and debouncing them is the caller's responsibility.

Test Plan:
1. Bench parameters TICK_DIV = 4, BUZZ_CYCLES = 3, FULL_LOAD = 24, SHORT_LOAD = 14. Apply reset, then hold run = 1. Required: count steps 24, 23, … 0 with one decrement every 4 cycles, 96 cycles total. expire_pulse is high for exactly 1 cycle, buzzer is high for exactly 3 cycles, expired stays 1, and count holds at 0 with no wrap to 31.
2. Pause/resume: with run = 1 from count 24, drop run after 6 cycles (count = 23, prescaler = 2) and hold it low for 10 cycles, then raise it again. Required: count holds at 23 throughout the pause, and the next decrement to 22 arrives 2 cycles after run returns to 1.
3. Short-reload rule:
   - At count = 20, pulse reload_short. Required: count stays 20 and the prescaler phase is unchanged.
   - At count = 9, pulse reload_short. Required: count = 14 and the prescaler is cleared.
   - At count = 0 with buzzer active, pulse reload_short. Required: count = 14, and buzzer and expired are 0 on the next edge.
4. Priority: assert reload_full and reload_short together on a tick cycle at count = 5. Required: count = 24 with no decrement. Separately, assert reset together with reload_short. Required: count = 24, buzzer = 0.
5. Reset mid-buzz: apply reset during the 2nd buzzer cycle. Required: buzzer = 0, expired = 0, count = 24, state HOLD, and no decrement occurs until run is asserted.
6. Width generalisation with FULL_LOAD = 30, SHORT_LOAD = 30, COUNT_W = 5, TICK_DIV = 2. Required: a full run counts 30 down to 0 in 60 cycles. reload_short at count = 29 loads 30; reload_short at count = 30 is ignored.

Source files
------------

// File: rtl/shot_clock_timer.sv
// Shot-clock countdown with built-in one-second prescaler, full/short reload,
// a one-cycle expiry strobe and a timed horn output.
//
//   state     | meaning
//   S_HOLD    | count frozen, prescaler keeps its partial second
//   S_RUN     | prescaler advancing, count decrements on each tick
//   S_EXPIRED | count reached 0; only a reload or reset leaves this state
module shot_clock_timer #(
    parameter int COUNT_W     = 5,
    parameter int FULL_LOAD   = 24,
    parameter int SHORT_LOAD  = 14,
    parameter int TICK_DIV    = 50000000,
    parameter int BUZZ_CYCLES = 50000000
) (
    input  logic               clock_in,
    input  logic               reset,
    input  logic               run,
    input  logic               reload_full,
    input  logic               reload_short,
    output logic [COUNT_W-1:0] count,
    output logic               expired,
    output logic               expire_pulse,
    output logic               buzzer
);

    localparam int PRESC_W = $clog2(TICK_DIV);
    localparam int BUZZ_W  = $clog2(BUZZ_CYCLES + 1);

    localparam logic [COUNT_W-1:0] FULL_C   = COUNT_W'(FULL_LOAD);
    localparam logic [COUNT_W-1:0] SHORT_C  = COUNT_W'(SHORT_LOAD);
    localparam logic [COUNT_W-1:0] ONE_C    = COUNT_W'(1);
    localparam logic [PRESC_W-1:0] PRESC_TC = PRESC_W'(TICK_DIV - 1);
    localparam logic [BUZZ_W-1:0]  BUZZ_C   = BUZZ_W'(BUZZ_CYCLES);
    localparam logic [BUZZ_W-1:0]  BUZZ_ONE = BUZZ_W'(1);

    typedef enum logic [1:0] {
        S_HOLD    = 2'd0,
        S_RUN     = 2'd1,
        S_EXPIRED = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [BUZZ_W-1:0]  buzz_cnt_q, buzz_cnt_d;
    logic               pend_q, pend_d;
    logic               expired_q, expired_d;
    logic               pulse_q, pulse_d;
    logic               buzzer_q, buzzer_d;

    logic do_full, do_short, advance;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        presc_d    = presc_q;
        buzz_cnt_d = buzz_cnt_q;
        expired_d  = expired_q;
        buzzer_d   = buzzer_q;
        pulse_d    = 1'b0;
        pend_d     = 1'b0;

        do_full  = reload_full;
        do_short = reload_short && (count_q < SHORT_C);
        advance  = run && (state_q != S_EXPIRED) && (count_q != '0);

        if (buzzer_q) begin
            if (buzz_cnt_q == BUZZ_ONE) begin
                buzzer_d   = 1'b0;
                buzz_cnt_d = '0;
            end else begin
                buzz_cnt_d = buzz_cnt_q - BUZZ_ONE;
            end
        end

        // Expiry outputs fire one edge after count lands on zero.
        if (pend_q) begin
            pulse_d    = 1'b1;
            expired_d  = 1'b1;
            buzzer_d   = 1'b1;
            buzz_cnt_d = BUZZ_C;
        end

        if (do_full || do_short) begin
            count_d    = do_full ? FULL_C : SHORT_C;
            presc_d    = '0;
            state_d    = run ? S_RUN : S_HOLD;
            expired_d  = 1'b0;
            buzzer_d   = 1'b0;
            buzz_cnt_d = '0;
            pulse_d    = 1'b0;
            pend_d     = 1'b0;
        end else if (advance) begin
            if (presc_q == PRESC_TC) begin
                presc_d = '0;
                count_d = count_q - ONE_C;
                if (count_q == ONE_C) begin
                    state_d = S_EXPIRED;
                    pend_d  = 1'b1;
                end else begin
                    state_d = S_RUN;
                end
            end else begin
                presc_d = presc_q + PRESC_W'(1);
                state_d = S_RUN;
            end
        end else if (state_q == S_RUN) begin
            state_d = S_HOLD;
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_q    <= S_HOLD;
            count_q    <= FULL_C;
            presc_q    <= '0;
            buzz_cnt_q <= '0;
            pend_q     <= 1'b0;
            expired_q  <= 1'b0;
            pulse_q    <= 1'b0;
            buzzer_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            presc_q    <= presc_d;
            buzz_cnt_q <= buzz_cnt_d;
            pend_q     <= pend_d;
            expired_q  <= expired_d;
            pulse_q    <= pulse_d;
            buzzer_q   <= buzzer_d;
        end
    end

    assign count        = count_q;
    assign expired      = expired_q;
    assign expire_pulse = pulse_q;
    assign buzzer       = buzzer_q;

endmodule
